// File: rtl/spi_counter_tx.sv
// Counter-to-SPI streamer: free-running tick divider, run/stop up/down counter,
// and a sender that bursts a coherent snapshot of the count through a byte SPI master.
module spi_counter_tx #(
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned TICK_HZ        = 100,
    parameter int unsigned MSB_FIRST      = 1,
    parameter int unsigned SEND_ON_CHANGE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run_toggle,
    input  logic                 clear,
    input  logic                 dir,
    input  logic                 ready,
    input  logic                 done,
    output logic [7:0]           tx_data,
    output logic                 start,
    output logic                 ss,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 running,
    output logic                 busy
);
    localparam int unsigned NBYTES = CNT_WIDTH / 8;
    localparam int unsigned DIV    = CLK_HZ / TICK_HZ;
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned SH_W   = IDX_W + 3;

    if ((CNT_WIDTH % 8) != 0 || CNT_WIDTH < 8 || CNT_WIDTH > 64 || DIV < 2) begin : g_bad_param
        $error("spi_counter_tx: illegal parameterisation");
    end

    // ---------------- tick divider ----------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (div_cnt == DIV_W'(DIV - 1));
            div_cnt <= (div_cnt == DIV_W'(DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // ---------------- counter FSM ----------------
    typedef enum logic {
        C_STOP = 1'b0,
        C_RUN  = 1'b1
    } cnt_state_t;

    cnt_state_t           cnt_state, cnt_state_next;
    logic [CNT_WIDTH-1:0] count_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_state <= C_STOP;
        else       cnt_state <= cnt_state_next;
    end

    always_comb begin
        cnt_state_next = cnt_state;
        if (run_toggle) cnt_state_next = (cnt_state == C_RUN) ? C_STOP : C_RUN;
    end

    // Tick uses the pre-toggle state; clear wins over a tick.
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (tick && cnt_state == C_RUN) begin
            count_next = dir ? count - CNT_WIDTH'(1) : count + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            running <= 1'b0;
        end else begin
            count   <= count_next;
            running <= (cnt_state_next == C_RUN);
        end
    end

    // ---------------- sender FSM ----------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_SEND   = 3'd2,
        S_WAIT   = 3'd3,
        S_FINISH = 3'd4
    } snd_state_t;

    snd_state_t           snd_state, snd_state_next;
    logic [CNT_WIDTH-1:0] snap, last_sent, src;
    logic [IDX_W-1:0]     idx, idx_next, sel;
    logic [SH_W-1:0]      shamt;
    logic [7:0]           tx_next;
    logic                 start_next, ss_next, busy_next;
    logic                 last_byte, want_send;

    assign last_byte = (idx == IDX_W'(NBYTES - 1));
    assign want_send = ready && (SEND_ON_CHANGE == 0 || count != last_sent);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) snd_state <= S_IDLE;
        else       snd_state <= snd_state_next;
    end

    always_comb begin
        snd_state_next = snd_state;
        case (snd_state)
            S_IDLE:   if (want_send) snd_state_next = S_LATCH;
            S_LATCH:  snd_state_next = S_SEND;
            S_SEND:   snd_state_next = S_WAIT;
            S_WAIT:   if (done) snd_state_next = last_byte ? S_FINISH : S_SEND;
            S_FINISH: snd_state_next = S_IDLE;
            default:  snd_state_next = S_IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so they register together with it;
    // on the LATCH->SEND edge the byte comes straight from count, which is what snap captures.
    always_comb begin
        idx_next   = idx;
        start_next = 1'b0;
        tx_next    = tx_data;
        busy_next  = (snd_state != S_IDLE);
        src        = (snd_state == S_LATCH) ? count : snap;
        case (snd_state)
            S_LATCH: idx_next = '0;
            S_WAIT:  if (done && !last_byte) idx_next = idx + IDX_W'(1);
            default: ;
        endcase
        sel   = (MSB_FIRST != 0) ? IDX_W'(NBYTES - 1) - idx_next : idx_next;
        shamt = {sel, 3'b000};
        if (snd_state_next == S_SEND) begin
            start_next = 1'b1;
            tx_next    = 8'(src >> shamt);
        end
        ss_next = !(snd_state_next inside {S_SEND, S_WAIT, S_FINISH});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap      <= '0;
            last_sent <= '0;
            idx       <= '0;
            tx_data   <= '0;
            start     <= 1'b0;
            ss        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            if (snd_state == S_LATCH) begin
                snap      <= count;
                last_sent <= count;
            end
            idx     <= idx_next;
            tx_data <= tx_next;
            start   <= start_next;
            ss      <= ss_next;
            busy    <= busy_next;
        end
    end

endmodule

// File: doc/spi_counter_tx.md
# spi_counter_tx

Parametrised counter-to-SPI streamer. It generates a time-base tick and maintains a run/stop up/down counter of configurable width. It serialises a coherent snapshot of the count as a burst of bytes through the byte-level SPI master handshake (ready/start/done), with SS framing the whole word. It sits between the front-panel controls (debounced pulses) and the SPI master core.

## Interface
Parameters:
- CNT_WIDTH, 16: counter width in bits; multiple of 8, range 8..64; NBYTES = CNT_WIDTH/8.
- CLK_HZ, 100_000_000: clk frequency.
- TICK_HZ, 100: count tick rate; DIV = CLK_HZ/TICK_HZ, must be ≥ 2.
- MSB_FIRST, 1: 1 = most-significant byte sent first, 0 = least-significant first.
- SEND_ON_CHANGE, 0: 0 = send every time ready is seen in IDLE; 1 = send only if the count differs from the last sent word.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clock clk.
- run_toggle  in  1  one-cycle pulse; toggles STOP/RUN.
- clear  in  1  one-cycle pulse; zeroes the counter.
- dir  in  1  0 = count up, 1 = count down; sampled on each tick.
- ready  in  1  SPI master idle and able to accept a byte.
- done  in  1  one-cycle pulse; current byte finished.
- tx_data  out  8  byte to transmit.
- start  out  1  one-cycle pulse requesting transmission of tx_data.
- ss  out  1  slave select, active-low.
- count  out  CNT_WIDTH  live counter value.
- running  out  1  1 while in RUN.
- busy  out  1  1 while a word transfer is in progress (sender not in IDLE).

## Operation
- **Tick divider:** free-running counter 0..DIV-1, independent of run state. tick = 1 for the one cycle after the divider reaches DIV-1, so the first tick comes DIV cycles after reset release.
- **Counter FSM** (states STOP, RUN; reset → STOP):
  - run_toggle flips the state.
  - In RUN, each tick adds +1 (dir=0) or −1 (dir=1), modulo 2^CNT_WIDTH. Wrap: max→0 going up, 0→max going down.
  - clear is honoured in either state: count = 0 next cycle, state unchanged. clear has priority over a tick in the same cycle.
  - run_toggle and clear in the same cycle: both take effect.
  - A tick in the same cycle as run_toggle is applied according to the pre-toggle state.
- **Sender FSM** (states IDLE, LATCH, SEND, WAIT, FINISH):
  - IDLE: go to LATCH if ready=1 and (SEND_ON_CHANGE=0 or count ≠ last_sent).
  - LATCH: snap = count; last_sent = count; idx = 0. Go to SEND.
  - SEND: ss=0; tx_data = byte idx of snap in the configured order; start pulse. Go to WAIT.
  - WAIT: on done, if idx = NBYTES-1 go to FINISH; otherwise idx+1 and go to SEND. done outside WAIT is ignored.
  - FINISH: ss=1; go to IDLE.
- Counter changes during a transfer never affect the bytes being sent; the snapshot guarantees coherence.
- After reset, last_sent = 0, so with SEND_ON_CHANGE=1 nothing is sent until the count becomes nonzero.

## Timing
- Reset values: tx_data=0, start=0, ss=1, count=0, running=0, busy=0. All outputs are registered.
- ready=1 in IDLE at edge N gives LATCH at N+1. At N+2, start=1, ss=0, and tx_data holds byte 0, all updating together.
- start lasts exactly one cycle. tx_data holds until the next byte's start.
- done at edge M (not the last byte) gives the next start pulse 1 cycle later.
- done on the last byte at edge M: FINISH follows, ss=1 is visible 2 edges after M, and busy=0 1 cycle later.
- ss stays low continuously from the first start through the last done plus 1 cycle; there is no gap between bytes.
- Minimum IDLE→IDLE overhead per word is 3 cycles plus NBYTES × (1 + the master's byte time).
- count reflects a tick or clear 1 cycle after it.
- Reset mid-transfer aborts at once: ss=1, start=0, FSM returns to IDLE, the counter returns to 0/STOP.

## Test plan
All scenarios use CLK_HZ=100, TICK_HZ=10 (DIV=10) and a bench SPI model that asserts done 8 cycles after start.
- **Reset values:** reset, release, idle 30 cycles with ready=0 → outputs hold reset values; count stays 0 in STOP.
- **Counting and clear:** run_toggle, dir=0, 35 cycles → count=3. Then clear coincident with a tick → count=0 next cycle, running still 1.
- **Down-count wrap:** from count=0 in RUN with dir=1, one tick → count=0xFFFF (CNT_WIDTH=16). Repeat with CNT_WIDTH=24 → 0xFFFFFF.
- **Burst framing and order:**
  - count=0x1234, ready=1, MSB_FIRST=1 → start pulses with tx_data 0x12 then 0x34; ss low across both and high 2 cycles after the second done.
  - MSB_FIRST=0 → 0x34 then 0x12.
  - CNT_WIDTH=32 with count 0xA1B2C3D4 → bytes A1, B2, C3, D4.
- **Coherence:** a tick occurs between byte 0 and byte 1 while count goes 0x00FF→0x0100 → bytes sent are 0x00, 0xFF.
- **SEND_ON_CHANGE=1 and reset mid-transfer:** ready held 1 with count stable → exactly one burst, then none until the next tick. Assert reset during the WAIT state → ss=1 and busy=0 immediately, no further start pulses.
